// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - time-multiplexes one Perceptron across the M neurons of a dense layer
// Optional perf_busy/perf_stall counters are built when LAYER_SEQ_PERF_EN is defined.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module layer_sequencer #(
  parameter int N          = 4,
  parameter int M          = 8,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int PE_LAT     = 0,
  localparam int MW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]     in_x,
  output logic                             wmem_en,
  output logic [MW-1:0]                    wmem_addr,
  input  logic [N-1:0][DATA_WIDTH-1:0]     wmem_w,
  input  logic [DATA_WIDTH-1:0]            wmem_b,
  output logic [N-1:0][DATA_WIDTH-1:0]     pe_x,
  output logic [N-1:0][DATA_WIDTH-1:0]     pe_w,
  output logic [DATA_WIDTH-1:0]            pe_b,
  input  logic [DATA_WIDTH-1:0]            pe_y,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MW-1:0]                    out_idx,
  output logic [DATA_WIDTH-1:0]            out_y,
`ifdef LAYER_SEQ_PERF_EN
  output logic [31:0]                      perf_busy,
  output logic [31:0]                      perf_stall,
`endif
  output logic                             out_last
);

  localparam int LW = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;
  localparam logic [MW-1:0] LAST_M   = MW'(M - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(PE_LAT);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EVAL, S_EMIT} state_e;

  state_e                          state_q, state_d;
  logic [MW-1:0]                   m_q;
  logic [LW-1:0]                   lat_q;
  logic [N-1:0][DATA_WIDTH-1:0]    pe_x_q, pe_w_q;
  logic [DATA_WIDTH-1:0]           pe_b_q, out_y_q;
  logic [MW-1:0]                   out_idx_q;
  logic                            eval_done;

  assign eval_done = (lat_q == LAST_LAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_EVAL;
      S_EVAL:  if (eval_done) state_d = S_EMIT;
      S_EMIT:  if (out_ready) state_d = (m_q == LAST_M) ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    wmem_en   = (state_q == S_FETCH);
    wmem_addr = (state_q == S_FETCH) ? m_q : '0;
    out_valid = (state_q == S_EMIT);
    out_last  = (state_q == S_EMIT) && (out_idx_q == LAST_M);
  end

  // Datapath registers only move in their owning state, so pe_* stay frozen through EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      lat_q     <= '0;
      pe_x_q    <= '0;
      pe_w_q    <= '0;
      pe_b_q    <= '0;
      out_y_q   <= '0;
      out_idx_q <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        pe_x_q <= in_x;
        m_q    <= '0;
      end
      if (state_q == S_LOAD) begin
        pe_w_q <= wmem_w;
        pe_b_q <= wmem_b;
        lat_q  <= '0;
      end
      if (state_q == S_EVAL) begin
        if (eval_done) begin
          out_y_q   <= pe_y;
          out_idx_q <= m_q;
        end else begin
          lat_q <= lat_q + 1'b1;
        end
      end
      if (state_q == S_EMIT && out_ready && m_q != LAST_M) m_q <= m_q + 1'b1;
    end
  end

  assign pe_x    = pe_x_q;
  assign pe_w    = pe_w_q;
  assign pe_b    = pe_b_q;
  assign out_y   = out_y_q;
  assign out_idx = out_idx_q;

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] busy_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (in_valid) begin
        busy_q  <= '0;
        stall_q <= '0;
      end
    end else begin
      if (busy_q != '1) busy_q <= busy_q + 32'd1;
      if (state_q == S_EMIT && !out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer
`timescale 1ns/1ps
module tb_layer_sequencer;
  localparam int DW = 8;
  typedef logic [3:0][DW-1:0] vec_t;

  localparam vec_t X1 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam vec_t X2 = {8'hFF, 8'd0, 8'd0, 8'd0};
  localparam vec_t X9 = {8'd9, 8'd9, 8'd9, 8'd9};
  localparam vec_t W1 = {8'd1, 8'd1, 8'd1, 8'd1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vec_t            in_x;
  logic            out_ready;
  vec_t            mem_w [2];
  logic [DW-1:0]   mem_b [2];

  function automatic logic [DW-1:0] pe_model(input vec_t x, input vec_t w, input logic [DW-1:0] b);
    int s;
    s = int'($signed(b));
    for (int i = 0; i < 4; i++) s += int'($signed(x[i])) * int'($signed(w[i]));
    if (s < 0) s = 0;
    return DW'(s);
  endfunction

  // dut_a: M=2 PE_LAT=0, dut_b: M=2 PE_LAT=2, dut_c: M=1 PE_LAT=0
  logic in_valid_a, in_ready_a, wmem_en_a, out_valid_a, out_last_a;
  logic [0:0] wmem_addr_a, out_idx_a;
  vec_t wmem_w_a, pe_x_a, pe_w_a;
  logic [DW-1:0] wmem_b_a, pe_b_a, pe_y_a, out_y_a;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_busy_a, perf_stall_a;
`endif

  logic in_valid_b, in_ready_b, wmem_en_b, out_valid_b, out_last_b;
  logic [0:0] wmem_addr_b, out_idx_b;
  vec_t wmem_w_b, pe_x_b, pe_w_b;
  logic [DW-1:0] wmem_b_b, pe_b_b, pe_y_b, out_y_b, p1_b, p2_b;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_busy_b, perf_stall_b;
`endif

  logic in_valid_c, in_ready_c, wmem_en_c, out_valid_c, out_last_c;
  logic [0:0] wmem_addr_c, out_idx_c;
  vec_t wmem_w_c, pe_x_c, pe_w_c;
  logic [DW-1:0] wmem_b_c, pe_b_c, pe_y_c, out_y_c;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_busy_c, perf_stall_c;
`endif

  layer_sequencer #(.N(4), .M(2), .DATA_WIDTH(DW), .PE_LAT(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_x(in_x),
    .wmem_en(wmem_en_a), .wmem_addr(wmem_addr_a), .wmem_w(wmem_w_a), .wmem_b(wmem_b_a),
    .pe_x(pe_x_a), .pe_w(pe_w_a), .pe_b(pe_b_a), .pe_y(pe_y_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_idx(out_idx_a), .out_y(out_y_a),
`ifdef LAYER_SEQ_PERF_EN
    .perf_busy(perf_busy_a), .perf_stall(perf_stall_a),
`endif
    .out_last(out_last_a));

  layer_sequencer #(.N(4), .M(2), .DATA_WIDTH(DW), .PE_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x),
    .wmem_en(wmem_en_b), .wmem_addr(wmem_addr_b), .wmem_w(wmem_w_b), .wmem_b(wmem_b_b),
    .pe_x(pe_x_b), .pe_w(pe_w_b), .pe_b(pe_b_b), .pe_y(pe_y_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_idx(out_idx_b), .out_y(out_y_b),
`ifdef LAYER_SEQ_PERF_EN
    .perf_busy(perf_busy_b), .perf_stall(perf_stall_b),
`endif
    .out_last(out_last_b));

  layer_sequencer #(.N(4), .M(1), .DATA_WIDTH(DW), .PE_LAT(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_x(in_x),
    .wmem_en(wmem_en_c), .wmem_addr(wmem_addr_c), .wmem_w(wmem_w_c), .wmem_b(wmem_b_c),
    .pe_x(pe_x_c), .pe_w(pe_w_c), .pe_b(pe_b_c), .pe_y(pe_y_c),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_idx(out_idx_c), .out_y(out_y_c),
`ifdef LAYER_SEQ_PERF_EN
    .perf_busy(perf_busy_c), .perf_stall(perf_stall_c),
`endif
    .out_last(out_last_c));

  // Weight memories return data exactly one cycle after the strobe, junk otherwise.
  always_ff @(posedge clk) begin
    if (wmem_en_a) begin wmem_w_a <= mem_w[wmem_addr_a]; wmem_b_a <= mem_b[wmem_addr_a]; end
    else begin wmem_w_a <= {4{8'h55}}; wmem_b_a <= 8'h55; end
    if (wmem_en_b) begin wmem_w_b <= mem_w[wmem_addr_b]; wmem_b_b <= mem_b[wmem_addr_b]; end
    else begin wmem_w_b <= {4{8'h55}}; wmem_b_b <= 8'h55; end
    if (wmem_en_c) begin wmem_w_c <= mem_w[wmem_addr_c]; wmem_b_c <= mem_b[wmem_addr_c]; end
    else begin wmem_w_c <= {4{8'h55}}; wmem_b_c <= 8'h55; end
    p1_b <= pe_model(pe_x_b, pe_w_b, pe_b_b);
    p2_b <= p1_b;
  end

  assign pe_y_a = pe_model(pe_x_a, pe_w_a, pe_b_a);
  assign pe_y_b = p2_b;
  assign pe_y_c = pe_model(pe_x_c, pe_w_c, pe_b_c);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || wmem_en_a !== 1'b0 || wmem_addr_a !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: in_ready=%b out_valid=%b wmem_en=%b wmem_addr=%b want 1 0 0 0",
        in_ready_a, out_valid_a, wmem_en_a, wmem_addr_a); end
    checks++;
    if (pe_x_a !== '0 || pe_w_a !== '0 || pe_b_a !== '0)
      begin errors++; $display("FAIL reset_pe: pe_x=%h pe_w=%h pe_b=%h want 0", pe_x_a, pe_w_a, pe_b_a); end
    checks++;
    if (out_y_a !== '0 || out_idx_a !== 1'b0 || out_last_a !== 1'b0)
      begin errors++; $display("FAIL reset_out: out_y=%h out_idx=%b out_last=%b want 0", out_y_a, out_idx_a, out_last_a); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_layer();
    out_ready = 1'b1;
    in_x = X1;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    checks++;
    if (wmem_en_a !== 1'b1 || wmem_addr_a !== 1'b0 || pe_x_a !== X1)
      begin errors++; $display("FAIL layer_fetch0: wmem_en=%b addr=%b pe_x=%h want 1 0 %h", wmem_en_a, wmem_addr_a, pe_x_a, X1); end
    tick(); tick();
    checks++;
    if (out_valid_a !== 1'b0)
      begin errors++; $display("FAIL layer_early_valid: out_valid=%b want 0", out_valid_a); end
    tick();
    checks++;
    if (out_valid_a !== 1'b1 || out_idx_a !== 1'b0 || out_y_a !== 8'd10 || out_last_a !== 1'b0)
      begin errors++; $display("FAIL layer_idx0: valid=%b idx=%b y=%0d last=%b want 1 0 10 0", out_valid_a, out_idx_a, out_y_a, out_last_a); end
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || wmem_en_a !== 1'b1 || wmem_addr_a !== 1'b1)
      begin errors++; $display("FAIL layer_fetch1: valid=%b wmem_en=%b addr=%b want 0 1 1", out_valid_a, wmem_en_a, wmem_addr_a); end
    tick(); tick(); tick();
    checks++;
    if (out_valid_a !== 1'b1 || out_idx_a !== 1'b1 || out_y_a !== 8'd0 || out_last_a !== 1'b1 || in_ready_a !== 1'b0)
      begin errors++; $display("FAIL layer_idx1: valid=%b idx=%b y=%0d last=%b in_ready=%b want 1 1 0 1 0",
        out_valid_a, out_idx_a, out_y_a, out_last_a, in_ready_a); end
    tick();
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0)
      begin errors++; $display("FAIL layer_done: in_ready=%b out_valid=%b want 1 0", in_ready_a, out_valid_a); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_x = X1;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick(); tick(); tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid_a !== 1'b1 || out_idx_a !== 1'b0 || out_y_a !== 8'd10 || wmem_en_a !== 1'b0 || out_last_a !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d]: valid=%b idx=%b y=%0d wmem_en=%b last=%b want 1 0 10 0 0",
          c, out_valid_a, out_idx_a, out_y_a, wmem_en_a, out_last_a); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || wmem_en_a !== 1'b1)
      begin errors++; $display("FAIL stall_release: valid=%b wmem_en=%b want 0 1", out_valid_a, wmem_en_a); end
    tick(); tick(); tick();
    checks++;
    if (out_valid_a !== 1'b1 || out_idx_a !== 1'b1 || out_y_a !== 8'd0 || out_last_a !== 1'b1)
      begin errors++; $display("FAIL stall_idx1: valid=%b idx=%b y=%0d last=%b want 1 1 0 1", out_valid_a, out_idx_a, out_y_a, out_last_a); end
    tick();
    checks++;
    if (in_ready_a !== 1'b1)
      begin errors++; $display("FAIL stall_done: in_ready=%b want 1", in_ready_a); end
  endtask

  task automatic test_busy_ignore();
    out_ready = 1'b1;
    in_x = X1;
    in_valid_a = 1'b1;
    tick();
    in_x = X9;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (in_ready_a !== 1'b0 || pe_x_a !== X1)
        begin errors++; $display("FAIL busy_hold[%0d]: in_ready=%b pe_x=%h want 0 %h", c, in_ready_a, pe_x_a, X1); end
      if (c == 4) begin
        checks++;
        if (out_valid_a !== 1'b1 || out_idx_a !== 1'b0 || out_y_a !== 8'd10)
          begin errors++; $display("FAIL busy_idx0: valid=%b idx=%b y=%0d want 1 0 10", out_valid_a, out_idx_a, out_y_a); end
      end
      if (c == 8) begin
        checks++;
        if (out_valid_a !== 1'b1 || out_idx_a !== 1'b1 || out_y_a !== 8'd0 || out_last_a !== 1'b1)
          begin errors++; $display("FAIL busy_idx1: valid=%b idx=%b y=%0d last=%b want 1 1 0 1", out_valid_a, out_idx_a, out_y_a, out_last_a); end
        in_valid_a = 1'b0;
      end
      tick();
    end
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0)
      begin errors++; $display("FAIL busy_done: in_ready=%b out_valid=%b want 1 0", in_ready_a, out_valid_a); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_x = X1;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || wmem_en_a !== 1'b0 || out_idx_a !== 1'b0 ||
        out_y_a !== '0 || pe_x_a !== '0 || pe_w_a !== '0 || pe_b_a !== '0 || out_last_a !== 1'b0)
      begin errors++; $display("FAIL rstmid_clear: in_ready=%b valid=%b wmem_en=%b idx=%b y=%h pe_x=%h pe_w=%h pe_b=%h want 1 0 0 0 0 0 0 0",
        in_ready_a, out_valid_a, wmem_en_a, out_idx_a, out_y_a, pe_x_a, pe_w_a, pe_b_a); end
    tick();
    rst = 1'b0;
    in_x = X2;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (out_valid_a !== 1'b1 || out_idx_a !== 1'b0 || out_y_a !== 8'd0)
      begin errors++; $display("FAIL rstmid_idx0: valid=%b idx=%b y=%0d want 1 0 0", out_valid_a, out_idx_a, out_y_a); end
    tick(); tick(); tick(); tick();
    checks++;
    if (out_valid_a !== 1'b1 || out_idx_a !== 1'b1 || out_y_a !== 8'd3 || out_last_a !== 1'b1)
      begin errors++; $display("FAIL rstmid_idx1: valid=%b idx=%b y=%0d last=%b want 1 1 3 1", out_valid_a, out_idx_a, out_y_a, out_last_a); end
    tick();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_x = X1;
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    tick(); tick();
    for (int e = 0; e < 3; e++) begin
      checks++;
      if (pe_x_b !== X1 || pe_w_b !== W1 || pe_b_b !== 8'd0 || out_valid_b !== 1'b0)
        begin errors++; $display("FAIL lat_eval[%0d]: pe_x=%h pe_w=%h pe_b=%h valid=%b want %h %h 00 0",
          e, pe_x_b, pe_w_b, pe_b_b, out_valid_b, X1, W1); end
      tick();
    end
    checks++;
    if (out_valid_b !== 1'b1 || out_idx_b !== 1'b0 || out_y_b !== 8'd10)
      begin errors++; $display("FAIL lat_idx0: valid=%b idx=%b y=%0d want 1 0 10", out_valid_b, out_idx_b, out_y_b); end
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (out_valid_b !== 1'b1 || out_idx_b !== 1'b1 || out_y_b !== 8'd0 || out_last_b !== 1'b1)
      begin errors++; $display("FAIL lat_idx1: valid=%b idx=%b y=%0d last=%b want 1 1 0 1", out_valid_b, out_idx_b, out_y_b, out_last_b); end
    tick();
    checks++;
    if (in_ready_b !== 1'b1)
      begin errors++; $display("FAIL lat_done: in_ready=%b want 1", in_ready_b); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_x = X1;
    in_valid_c = 1'b1;
    tick();
    in_valid_c = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (out_valid_c !== 1'b1 || out_idx_c !== 1'b0 || out_y_c !== 8'd10 || out_last_c !== 1'b1)
      begin errors++; $display("FAIL single_out: valid=%b idx=%b y=%0d last=%b want 1 0 10 1", out_valid_c, out_idx_c, out_y_c, out_last_c); end
    tick();
    checks++;
    if (in_ready_c !== 1'b1 || out_valid_c !== 1'b0)
      begin errors++; $display("FAIL single_done: in_ready=%b valid=%b want 1 0", in_ready_c, out_valid_c); end
  endtask

`ifdef LAYER_SEQ_PERF_EN
  task automatic test_perf();
    out_ready = 1'b0;
    in_x = X1;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick(); tick(); tick();
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick();
    tick(); tick(); tick();
    tick();
    checks++;
    if (in_ready_a !== 1'b1 || perf_busy_a !== 32'd11 || perf_stall_a !== 32'd3)
      begin errors++; $display("FAIL perf_counts: in_ready=%b busy=%0d stall=%0d want 1 11 3", in_ready_a, perf_busy_a, perf_stall_a); end
  endtask
`endif

  initial begin
    mem_w[0] = W1;
    mem_w[1] = {4{8'hFF}};
    mem_b[0] = 8'd0;
    mem_b[1] = 8'd2;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_valid_c = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    test_reset();
    test_layer();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    test_latency();
    test_single();
`ifdef LAYER_SEQ_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
